// File: rtl/task3_arc4_top.sv
// ARC4 decryption top for a DE1-SoC style board.
// Reads a length-prefixed ciphertext from ct_mem, runs ARC4 init/KSA/PRGA
// over s_mem with a key taken from SW, and writes the length-prefixed
// plaintext to pt_mem.
// Ports:
//   CLOCK_50   system clock
//   KEY[3]     asynchronous active-low reset; KEY[2:0] unused
//   SW         key value, key = {14'b0, SW}
//   HEX0..HEX5 active-low 7-segment digits (blank unless ARC4_HEX_KEY_EN)
//   LEDR       LEDR[0] = done, LEDR[9:1] = 0
// Optional feature macro: ARC4_HEX_KEY_EN shows the captured key on
// HEX5..HEX0 once the run is done.
module task3_arc4_top #(
   parameter int unsigned KEY_BYTES = 3,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic       CLOCK_50,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   output logic [9:0] LEDR
);
   localparam int unsigned AW    = $clog2(MEM_DEPTH);
   localparam int unsigned KEY_W = KEY_BYTES * 8;

   typedef enum logic [3:0] {
      S_INIT, S_KSA_RD_I, S_KSA_RD_J, S_KSA_WR_I, S_KSA_WR_J,
      S_PR_LEN, S_PR_LEN_WR, S_PR_RD_I, S_PR_RD_J, S_PR_WR_I,
      S_PR_WR_J, S_PR_RD_PAD, S_PR_WR_PT, S_DONE
   } state_t;

   logic clk, rst_n;
   assign clk   = CLOCK_50;
   assign rst_n = KEY[3];

   // Behavioural single-port RAMs, 1-cycle read latency, never reset
   logic [7:0]    s_mem  [MEM_DEPTH];
   logic [7:0]    ct_mem [MEM_DEPTH];
   logic [7:0]    pt_mem [MEM_DEPTH];
   logic [AW-1:0] s_addr, ct_addr, pt_addr;
   logic [7:0]    s_wdata, pt_wdata, s_rdata, ct_rdata, pt_rdata;
   logic          s_we, pt_we, ct_we;

   state_t            state, state_n;
   logic [7:0]        i, i_n, j, j_n, k, k_n, len, len_n, si, si_n, sj, sj_n;
   logic [KEY_W-1:0]  key, key_n, key_rot, key_rot_n;
   logic [7:0]        ksa_j, prga_j, pad_idx;
   logic              done_q;
   logic [5:0][6:0]   hex_n, hex_q;

   // CT is loaded from outside the design; no internal writer
   assign ct_we = 1'b0;

   always_ff @(posedge clk) begin
      if (s_we) s_mem[s_addr] <= s_wdata;
      s_rdata <= s_mem[s_addr];
   end

   always_ff @(posedge clk) begin
      if (ct_we) ct_mem[ct_addr] <= 8'h00;
      ct_rdata <= ct_mem[ct_addr];
   end

   always_ff @(posedge clk) begin
      if (pt_we) pt_mem[pt_addr] <= pt_wdata;
      pt_rdata <= pt_mem[pt_addr];
   end

   // Top byte of key_rot is always keybyte[i mod KEY_BYTES]
   assign ksa_j   = 8'(j + s_rdata + key_rot[KEY_W-1 -: 8]);
   assign prga_j  = 8'(j + s_rdata);
   assign pad_idx = 8'(si + sj);

`ifdef ARC4_HEX_KEY_EN
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
      endcase
   endfunction
`endif

   // Next-state, datapath and memory-port control
   always_comb begin
      state_n   = state;
      i_n       = i;
      j_n       = j;
      k_n       = k;
      len_n     = len;
      si_n      = si;
      sj_n      = sj;
      key_n     = key;
      key_rot_n = key_rot;
      s_addr    = AW'(i);
      s_we      = 1'b0;
      s_wdata   = s_rdata;
      ct_addr   = '0;
      pt_addr   = AW'(k);
      pt_we     = 1'b0;
      pt_wdata  = 8'(ct_rdata ^ s_rdata);
      case (state)
         S_INIT: begin
            s_we    = 1'b1;
            s_wdata = i;
            i_n     = 8'(i + 8'd1);
            // First INIT cycle is the first clock after reset release
            if (i == 8'd0) key_n = KEY_W'(SW);
            if (i == 8'hFF) begin
               j_n       = 8'd0;
               key_rot_n = key;
               state_n   = S_KSA_RD_I;
            end
         end
         S_KSA_RD_I: state_n = S_KSA_RD_J;
         S_KSA_RD_J: begin
            si_n    = s_rdata;
            j_n     = ksa_j;
            s_addr  = AW'(ksa_j);
            state_n = S_KSA_WR_I;
         end
         S_KSA_WR_I: begin
            s_we    = 1'b1;
            s_wdata = s_rdata;
            state_n = S_KSA_WR_J;
         end
         S_KSA_WR_J: begin
            s_we      = 1'b1;
            s_addr    = AW'(j);
            s_wdata   = si;
            i_n       = 8'(i + 8'd1);
            key_rot_n = {key_rot[KEY_W-9:0], key_rot[KEY_W-1 -: 8]};
            state_n   = (i == 8'hFF) ? S_PR_LEN : S_KSA_RD_I;
         end
         S_PR_LEN: begin
            i_n     = 8'd0;
            j_n     = 8'd0;
            k_n     = 8'd1;
            state_n = S_PR_LEN_WR;
         end
         S_PR_LEN_WR: begin
            len_n    = ct_rdata;
            pt_we    = 1'b1;
            pt_addr  = '0;
            pt_wdata = ct_rdata;
            state_n  = (ct_rdata == 8'd0) ? S_DONE : S_PR_RD_I;
         end
         S_PR_RD_I: begin
            i_n     = 8'(i + 8'd1);
            s_addr  = AW'(8'(i + 8'd1));
            state_n = S_PR_RD_J;
         end
         S_PR_RD_J: begin
            si_n    = s_rdata;
            j_n     = prga_j;
            s_addr  = AW'(prga_j);
            state_n = S_PR_WR_I;
         end
         S_PR_WR_I: begin
            sj_n    = s_rdata;
            s_we    = 1'b1;
            s_wdata = s_rdata;
            state_n = S_PR_WR_J;
         end
         S_PR_WR_J: begin
            s_we    = 1'b1;
            s_addr  = AW'(j);
            s_wdata = si;
            state_n = S_PR_RD_PAD;
         end
         S_PR_RD_PAD: begin
            s_addr  = AW'(pad_idx);
            ct_addr = AW'(k);
            state_n = S_PR_WR_PT;
         end
         S_PR_WR_PT: begin
            pt_we   = 1'b1;
            k_n     = 8'(k + 8'd1);
            state_n = (k == len) ? S_DONE : S_PR_RD_I;
         end
         default: ;
      endcase
      hex_n = {6{7'b1111111}};
`ifdef ARC4_HEX_KEY_EN
      if (state_n == S_DONE)
         for (int d = 0; d < 6; d++) hex_n[d] = seg7(key_n[4*d +: 4]);
`endif
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_INIT;
         i       <= 8'd0;
         j       <= 8'd0;
         k       <= 8'd0;
         len     <= 8'd0;
         si      <= 8'd0;
         sj      <= 8'd0;
         key     <= '0;
         key_rot <= '0;
         done_q  <= 1'b0;
         hex_q   <= {6{7'b1111111}};
      end else begin
         state   <= state_n;
         i       <= i_n;
         j       <= j_n;
         k       <= k_n;
         len     <= len_n;
         si      <= si_n;
         sj      <= sj_n;
         key     <= key_n;
         key_rot <= key_rot_n;
         done_q  <= (state_n == S_DONE);
         hex_q   <= hex_n;
      end
   end

   assign HEX0 = hex_q[0];
   assign HEX1 = hex_q[1];
   assign HEX2 = hex_q[2];
   assign HEX3 = hex_q[3];
   assign HEX4 = hex_q[4];
   assign HEX5 = hex_q[5];
   assign LEDR = {9'b0, done_q};

   logic unused_ok;
   assign unused_ok = &{1'b0, KEY[2:0], pt_rdata};
endmodule

// File: tb/tb_task3_arc4_top.sv
// Self-checking bench for task3_arc4_top: reset state, KSA result,
// max-length decrypt, mid-run reset, short decrypt with SW change after
// capture, and HEX display after done.
module tb_task3_arc4_top;
   logic       CLOCK_50 = 1'b0;
   logic [3:0] KEY;
   logic [9:0] SW;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [9:0] LEDR;

   int checks   = 0;
   int failures = 0;

   logic [7:0] ms   [256];
   logic [7:0] ks   [256];
   logic [7:0] ctv  [256];
   logic [7:0] exp5 [256];

   task3_arc4_top dut (
      .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
      .HEX4(HEX4), .HEX5(HEX5), .LEDR(LEDR)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference ARC4 key schedule for a 3-byte key
   task automatic model_ksa(input logic [23:0] key);
      logic [7:0] jj, t, kb;
      for (int n = 0; n < 256; n++) ms[n] = 8'(n);
      jj = 8'd0;
      for (int n = 0; n < 256; n++) begin
         case (n % 3)
            0:       kb = key[23:16];
            1:       kb = key[15:8];
            default: kb = key[7:0];
         endcase
         jj = 8'(jj + ms[n] + kb);
         t = ms[n]; ms[n] = ms[jj]; ms[jj] = t;
      end
   endtask

   // Reference keystream bytes ks[1..len] from the current ms
   task automatic model_stream(input int len);
      logic [7:0] ii, jj, t, idx;
      ii = 8'd0; jj = 8'd0;
      for (int n = 1; n <= len; n++) begin
         ii = 8'(ii + 8'd1);
         jj = 8'(jj + ms[ii]);
         t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
         idx = 8'(ms[ii] + ms[jj]);
         ks[n] = ms[idx];
      end
   endtask

   task automatic hold_reset();
      @(negedge CLOCK_50);
      KEY[3] = 1'b0;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic release_reset();
      @(negedge CLOCK_50);
      KEY[3] = 1'b1;
   endtask

   task automatic wait_done(input int bound, input string tag);
      int n;
      n = 0;
      while (LEDR[0] !== 1'b1 && n < bound) begin
         @(posedge CLOCK_50);
         #1;
         n++;
      end
      check({tag, "_done"}, 32'(LEDR[0]), 32'd1);
   endtask

   initial begin
      logic [7:0] ptxt;
      KEY = 4'b0111;
      SW  = 10'h018;
      @(posedge CLOCK_50);
      #1;
      check("rst_hex0", 32'(HEX0), 32'h7F);
      check("rst_hex1", 32'(HEX1), 32'h7F);
      check("rst_hex2", 32'(HEX2), 32'h7F);
      check("rst_hex3", 32'(HEX3), 32'h7F);
      check("rst_hex4", 32'(HEX4), 32'h7F);
      check("rst_hex5", 32'(HEX5), 32'h7F);
      check("rst_ledr", 32'(LEDR), 32'h0);

      // Init + KSA with key 000000, empty message
      SW = 10'h000;
      dut.ct_mem[0] = 8'd0;
      release_reset();
      wait_done(1400, "ksa");
      model_ksa(24'h000000);
      for (int n = 0; n < 256; n++)
         check($sformatf("ksa_s%0d", n), 32'(dut.s_mem[n]), 32'(ms[n]));
      check("ksa_pt0", 32'(dut.pt_mem[0]), 32'd0);

      // Max length, key 0x3FF, random ciphertext
      hold_reset();
      SW = 10'h3FF;
      dut.ct_mem[0] = 8'd255;
      for (int n = 1; n < 256; n++) begin
         ctv[n] = 8'($urandom);
         dut.ct_mem[n] = ctv[n];
      end
      release_reset();
      wait_done(4000, "max");
      model_ksa(24'h0003FF);
      model_stream(255);
      check("max_pt0", 32'(dut.pt_mem[0]), 32'd255);
      for (int n = 1; n < 256; n++)
         check($sformatf("max_pt%0d", n), 32'(dut.pt_mem[n]), 32'(ctv[n] ^ ks[n]));

      // Reset drops LEDR asynchronously, before any clock edge
      @(negedge CLOCK_50);
      KEY[3] = 1'b0;
      #1;
      check("async_ledr", 32'(LEDR), 32'h0);
      release_reset();
      repeat (2000) @(posedge CLOCK_50);
      #1;
      check("mid_busy", 32'(LEDR), 32'h0);
      // Abort in PRGA, restart with key 0x018
      @(negedge CLOCK_50);
      KEY[3] = 1'b0;
      #1;
      check("mid_ledr", 32'(LEDR), 32'h0);
      SW = 10'h018;
      @(posedge CLOCK_50);
      release_reset();
      wait_done(4000, "mid");
      model_ksa(24'h000018);
      model_stream(255);
      for (int n = 1; n < 256; n++) begin
         exp5[n] = ctv[n] ^ ks[n];
         check($sformatf("mid_pt%0d", n), 32'(dut.pt_mem[n]), 32'(exp5[n]));
      end

      // Short decrypt, key 0x018; SW change after capture is ignored
      hold_reset();
      dut.ct_mem[0] = 8'd20;
      for (int n = 1; n <= 20; n++) begin
         ptxt = 8'(n * 7 + 3);
         dut.ct_mem[n] = ptxt ^ ks[n];
      end
      release_reset();
      repeat (5) @(posedge CLOCK_50);
      SW = 10'h3FF;
      wait_done(4000, "dec");
      check("dec_pt0", 32'(dut.pt_mem[0]), 32'd20);
      for (int n = 1; n <= 20; n++) begin
         ptxt = 8'(n * 7 + 3);
         check($sformatf("dec_pt%0d", n), 32'(dut.pt_mem[n]), 32'(ptxt));
      end
      check("dec_pt21_kept", 32'(dut.pt_mem[21]), 32'(exp5[21]));
      check("dec_pt255_kept", 32'(dut.pt_mem[255]), 32'(exp5[255]));
      check("dec_ledr_hi", 32'(LEDR[9:1]), 32'h0);

`ifdef ARC4_HEX_KEY_EN
      check("hex0", 32'(HEX0), 32'h00);   // 8
      check("hex1", 32'(HEX1), 32'h79);   // 1
      check("hex2", 32'(HEX2), 32'h40);   // 0
      check("hex3", 32'(HEX3), 32'h40);
      check("hex4", 32'(HEX4), 32'h40);
      check("hex5", 32'(HEX5), 32'h40);
`else
      check("hex0", 32'(HEX0), 32'h7F);
      check("hex1", 32'(HEX1), 32'h7F);
      check("hex2", 32'(HEX2), 32'h7F);
      check("hex3", 32'(HEX3), 32'h7F);
      check("hex4", 32'(HEX4), 32'h7F);
      check("hex5", 32'(HEX5), 32'h7F);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
